proc_trace_buf: RTL and testbench

- Downstream consumer of the single-cycle processor's trace interface (trace_val/trace_addr/trace_data).
- Captures every retired register-writeback trace record into a FIFO and drains it over a valid/ready stream to a test harness or host link.
- Decouples the processor, which can emit one record per cycle with no backpressure, from a slower consumer.
- Counts any records lost to overflow.

---
 rtl/proc_trace_buf.sv | 72 +++++++
 tb/tb_proc_trace_buf.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/proc_trace_buf.sv
// proc_trace_buf: FIFO capture of processor trace records with drop accounting
module proc_trace_buf #(
    parameter int DEPTH = 16,
    parameter int DROPW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_val,
    input  logic [31:0]              trace_addr,
    input  logic [31:0]              trace_data,
    output logic                     drain_val,
    input  logic                     drain_rdy,
    output logic [31:0]              drain_addr,
    output logic [31:0]              drain_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     ovf,
    output logic [DROPW-1:0]         drop_cnt,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [63:0]      mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic [DROPW-1:0] drop_q, drop_d;
    logic             full, pop, push, drop;

    // Handshake decode and next-state for pointers, occupancy and drop accounting
    always_comb begin
        full   = occ_q == OW'(DEPTH);
        pop    = drain_val && drain_rdy;
        push   = trace_val && (!full || pop);
        drop   = trace_val && full && !pop;
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        occ_d  = (push && !pop) ? occ_q + OW'(1) : (pop && !push) ? occ_q - OW'(1) : occ_q;
        ovf_d  = drop || (ovf_q && !ovf_clr);
        drop_d = ovf_clr ? (drop ? DROPW'(1) : '0)
                         : (drop && drop_q != '1) ? drop_q + DROPW'(1) : drop_q;
    end

    // Control state; reset discards queued records by zeroing pointers and count
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Record storage; read asynchronously so the head is visible as soon as occupancy rises
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_q] <= {trace_addr, trace_data};
    end

    assign drain_val  = occ_q != '0;
    assign drain_addr = drain_val ? mem_q[rd_q][63:32] : '0;
    assign drain_data = drain_val ? mem_q[rd_q][31:0] : '0;
    assign occupancy  = occ_q;
    assign ovf        = ovf_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_proc_trace_buf.sv
// tb_proc_trace_buf: directed checks of the trace capture FIFO
module tb_proc_trace_buf;
    logic        clk = 0;
    logic        rst = 0;
    logic        trace_val = 0;
    logic [31:0] trace_addr = 0;
    logic [31:0] trace_data = 0;
    logic        drain_val;
    logic        drain_rdy = 0;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [4:0]  occupancy;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr = 0;
    int checks = 0;
    int errors = 0;

    proc_trace_buf #(.DEPTH(16), .DROPW(8)) dut (
        .clk(clk), .rst(rst), .trace_val(trace_val), .trace_addr(trace_addr),
        .trace_data(trace_data), .drain_val(drain_val), .drain_rdy(drain_rdy),
        .drain_addr(drain_addr), .drain_data(drain_data), .occupancy(occupancy),
        .ovf(ovf), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_val", drain_val, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_addr", drain_addr, 0);
        chk("rst_data", drain_data, 0);
        rst = 1;
        // single record, stall, then pop
        trace_val = 1; trace_addr = 32'h4; trace_data = 32'hDEADBEEF;
        step();
        trace_val = 0;
        chk("t1_val", drain_val, 1);
        chk("t1_addr", drain_addr, 32'h4);
        chk("t1_data", drain_data, 32'hDEADBEEF);
        chk("t1_occ", occupancy, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_hold_data", drain_data, 32'hDEADBEEF);
            chk("t1_hold_occ", occupancy, 1);
        end
        drain_rdy = 1;
        step();
        drain_rdy = 0;
        chk("t1_pop_occ", occupancy, 0);
        chk("t1_pop_val", drain_val, 0);
        // fill to 16, then drop one
        for (int i = 0; i < 16; i++) begin
            trace_val = 1; trace_addr = 32'(i * 4); trace_data = 32'(i);
            step();
        end
        trace_val = 0;
        chk("t2_full_occ", occupancy, 16);
        chk("t2_full_ovf", ovf, 0);
        trace_val = 1; trace_data = 32'd16;
        step();
        trace_val = 0;
        chk("t2_drop_ovf", ovf, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_drop_occ", occupancy, 16);
        chk("t2_head", drain_data, 0);
        // full with simultaneous pop
        trace_val = 1; trace_addr = 32'h0; trace_data = 32'h99; drain_rdy = 1;
        step();
        trace_val = 0;
        chk("t3_occ", occupancy, 16);
        chk("t3_drop", drop_cnt, 1);
        for (int i = 1; i < 16; i++) begin
            chk("t2_order_data", drain_data, 32'(i));
            chk("t2_order_addr", drain_addr, 32'(i * 4));
            step();
        end
        chk("t3_last", drain_data, 32'h99);
        step();
        drain_rdy = 0;
        chk("t3_empty", occupancy, 0);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("clr_ovf", ovf, 0);
        chk("clr_drop", drop_cnt, 0);
        // streaming with wrap
        drain_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            trace_val = 1; trace_data = 32'(i + 'h100);
            step();
            chk("t4_data", drain_data, 32'(i + 'h100));
            chk("t4_occ", occupancy, 1);
        end
        trace_val = 0;
        step();
        drain_rdy = 0;
        chk("t4_empty", occupancy, 0);
        chk("t4_ovf", ovf, 0);
        chk("t4_drop", drop_cnt, 0);
        // saturation
        for (int i = 0; i < 16; i++) begin
            trace_val = 1; trace_data = 32'(i);
            step();
        end
        for (int i = 0; i < 300; i++) step();
        trace_val = 0;
        chk("t5_sat", drop_cnt, 255);
        chk("t5_ovf", ovf, 1);
        chk("t5_occ", occupancy, 16);
        chk("t5_head", drain_data, 0);
        ovf_clr = 1;
        step();
        chk("t5_clr_ovf", ovf, 0);
        chk("t5_clr_drop", drop_cnt, 0);
        trace_val = 1;
        step();
        ovf_clr = 0; trace_val = 0;
        chk("t5_clrdrop_ovf", ovf, 1);
        chk("t5_clrdrop_cnt", drop_cnt, 1);
        chk("t5_clr_occ", occupancy, 16);
        // reset mid-operation
        rst = 0;
        step();
        rst = 1;
        for (int i = 0; i < 10; i++) begin
            trace_val = 1; trace_data = 32'(i + 'h200);
            step();
        end
        trace_val = 0;
        chk("t6_occ10", occupancy, 10);
        rst = 0; trace_val = 1;
        step();
        chk("t6_occ", occupancy, 0);
        chk("t6_val", drain_val, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_data0", drain_data, 0);
        rst = 1; trace_addr = 32'hA5A5; trace_data = 32'h12345678;
        step();
        trace_val = 0;
        chk("t6_new_val", drain_val, 1);
        chk("t6_new_addr", drain_addr, 32'hA5A5);
        chk("t6_new_data", drain_data, 32'h12345678);
        chk("t6_new_occ", occupancy, 1);
        drain_rdy = 1;
        step();
        drain_rdy = 0;
        chk("t6_drained", occupancy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
